// File: rtl/mpsoc_wb_ext_arbiter.sv
// Round-robin Wishbone arbiter: NODES masters share one slave (SPRAM) port.
// Optional slave watchdog compiled in with `define MPSOC_WB_ARB_TIMEOUT_EN.
module mpsoc_wb_ext_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int NODES   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NODES-1:0][AW-1:0]  m_adr_i,
  input  logic [NODES-1:0][DW-1:0]  m_dat_i,
  input  logic [NODES-1:0][3:0]     m_sel_i,
  input  logic [NODES-1:0]          m_we_i,
  input  logic [NODES-1:0][1:0]     m_bte_i,
  input  logic [NODES-1:0][2:0]     m_cti_i,
  input  logic [NODES-1:0]          m_cyc_i,
  input  logic [NODES-1:0]          m_stb_i,
  output logic [NODES-1:0]          m_ack_o,
  output logic [NODES-1:0]          m_err_o,
  output logic [NODES-1:0]          m_rty_o,
  output logic [NODES-1:0][DW-1:0]  m_dat_o,
  output logic [AW-1:0]             s_adr_o,
  output logic [DW-1:0]             s_dat_o,
  output logic [3:0]                s_sel_o,
  output logic                      s_we_o,
  output logic [1:0]                s_bte_o,
  output logic [2:0]                s_cti_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  input  logic                      s_ack_i,
  input  logic                      s_err_i,
  input  logic                      s_rty_i,
  input  logic [DW-1:0]             s_dat_i,
  output logic [NODES-1:0]          grant_o,
  output logic                      timeout_o
);

  localparam int PW = (NODES > 1) ? $clog2(NODES) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q;
  logic [PW-1:0]    ptr_q;
  logic [PW-1:0]    gidx_q;
  logic [NODES-1:0] grant_q;
  logic [PW-1:0]    ptr_d;
  logic [PW-1:0]    next_idx;
  logic             found;
  logic             stb_raw;
  logic             expire;

  // First requester at or after ptr, wrapping modulo NODES.
  always_comb begin
    found    = 1'b0;
    next_idx = '0;
    for (int i = 0; i < NODES; i++) begin
      if (!found && m_cyc_i[(int'(ptr_q) + i) % NODES]) begin
        found    = 1'b1;
        next_idx = PW'((int'(ptr_q) + i) % NODES);
      end
    end
  end

  assign ptr_d = (gidx_q == PW'(NODES - 1)) ? '0 : gidx_q + PW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      grant_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            state_q <= BUSY;
            gidx_q  <= next_idx;
            grant_q <= {{(NODES-1){1'b0}}, 1'b1} << next_idx;
          end
        end
        BUSY: begin
          if (!m_cyc_i[gidx_q]) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= ptr_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_bte_o = '0;
    s_cti_o = '0;
    s_cyc_o = 1'b0;
    stb_raw = 1'b0;
    if (state_q == BUSY) begin
      s_adr_o = m_adr_i[gidx_q];
      s_dat_o = m_dat_i[gidx_q];
      s_sel_o = m_sel_i[gidx_q];
      s_we_o  = m_we_i[gidx_q];
      s_bte_o = m_bte_i[gidx_q];
      s_cti_o = m_cti_i[gidx_q];
      s_cyc_o = m_cyc_i[gidx_q];
      stb_raw = m_stb_i[gidx_q];
    end
  end

`ifdef MPSOC_WB_ARB_TIMEOUT_EN
  logic [15:0] wdog_q;
  logic        slave_resp;
  logic        stall;

  assign slave_resp = s_ack_i | s_err_i | s_rty_i;
  assign stall      = stb_raw & ~slave_resp;
  // A response in the expiry cycle wins, so the watchdog only fires on a true stall.
  assign expire     = stall && (wdog_q == 16'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_q <= '0;
    end else if (stall && !expire) begin
      wdog_q <= wdog_q + 16'd1;
    end else begin
      wdog_q <= '0;
    end
  end
`else
  assign expire = 1'b0;
`endif

  assign s_stb_o   = stb_raw & ~expire;
  assign timeout_o = expire;
  assign grant_o   = grant_q;
  assign m_ack_o   = grant_q & {NODES{s_ack_i}};
  assign m_err_o   = grant_q & {NODES{s_err_i | expire}};
  assign m_rty_o   = grant_q & {NODES{s_rty_i}};
  assign m_dat_o   = {NODES{s_dat_i}};

endmodule

// File: tb/tb_mpsoc_wb_ext_arbiter.sv
// Directed bench for mpsoc_wb_ext_arbiter (16 masters, TIMEOUT = 8).
// Watchdog expectations follow whether MPSOC_WB_ARB_TIMEOUT_EN is defined.
module tb_mpsoc_wb_ext_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int N  = 16;
  localparam int TO = 8;

  logic                 clk;
  logic                 rst;
  logic [N-1:0][AW-1:0] mAdrI;
  logic [N-1:0][DW-1:0] mDatI;
  logic [N-1:0][3:0]    mSelI;
  logic [N-1:0]         mWeI;
  logic [N-1:0][1:0]    mBteI;
  logic [N-1:0][2:0]    mCtiI;
  logic [N-1:0]         mCycI;
  logic [N-1:0]         mStbI;
  logic [N-1:0]         mAckO;
  logic [N-1:0]         mErrO;
  logic [N-1:0]         mRtyO;
  logic [N-1:0][DW-1:0] mDatO;
  logic [AW-1:0]        sAdrO;
  logic [DW-1:0]        sDatO;
  logic [3:0]           sSelO;
  logic                 sWeO;
  logic [1:0]           sBteO;
  logic [2:0]           sCtiO;
  logic                 sCycO;
  logic                 sStbO;
  logic                 sAckI;
  logic                 sErrI;
  logic                 sRtyI;
  logic [DW-1:0]        sDatI;
  logic [N-1:0]         grantO;
  logic                 timeoutO;

  int nChecks = 0;
  int nFail   = 0;

  mpsoc_wb_ext_arbiter #(.AW(AW), .DW(DW), .NODES(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m_adr_i(mAdrI), .m_dat_i(mDatI), .m_sel_i(mSelI), .m_we_i(mWeI),
    .m_bte_i(mBteI), .m_cti_i(mCtiI), .m_cyc_i(mCycI), .m_stb_i(mStbI),
    .m_ack_o(mAckO), .m_err_o(mErrO), .m_rty_o(mRtyO), .m_dat_o(mDatO),
    .s_adr_o(sAdrO), .s_dat_o(sDatO), .s_sel_o(sSelO), .s_we_o(sWeO),
    .s_bte_o(sBteO), .s_cti_o(sCtiO), .s_cyc_o(sCycO), .s_stb_o(sStbO),
    .s_ack_i(sAckI), .s_err_i(sErrI), .s_rty_i(sRtyI), .s_dat_i(sDatI),
    .grant_o(grantO), .timeout_o(timeoutO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    mAdrI = '0; mDatI = '0; mSelI = '0; mWeI = '0;
    mBteI = '0; mCtiI = '0; mCycI = '0; mStbI = '0;
    sAckI = 1'b0; sErrI = 1'b0; sRtyI = 1'b0; sDatI = '0;
  endtask

  task automatic doReset();
    clearInputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    clearInputs();
    rst = 1'b0;
    mCycI[2] = 1'b1; mStbI[2] = 1'b1; sAckI = 1'b1; sErrI = 1'b1;
    tick();
    tick();
    nChecks++; if (grantO !== 16'h0000) begin nFail++; $display("[TB] FAIL reset_grant got %h want 0000", grantO); end
    nChecks++; if ({sCycO, sStbO} !== 2'b00) begin nFail++; $display("[TB] FAIL reset_cyc_stb got %b want 00", {sCycO, sStbO}); end
    nChecks++; if (mAckO !== 16'h0000 || mErrO !== 16'h0000) begin nFail++; $display("[TB] FAIL reset_resp ack %h err %h want 0", mAckO, mErrO); end
    nChecks++; if (timeoutO !== 1'b0) begin nFail++; $display("[TB] FAIL reset_timeout got %b want 0", timeoutO); end
    clearInputs();
  endtask

  task automatic test_single();
    doReset();
    mCycI[3] = 1'b1; mStbI[3] = 1'b1; mAdrI[3] = 32'hA000_0030;
    mDatI[3] = 32'h1234_5678; mWeI[3] = 1'b1; mSelI[3] = 4'hA;
    #1;
    nChecks++; if (grantO !== 16'h0000 || sCycO !== 1'b0) begin nFail++; $display("[TB] FAIL single_no_same_cycle grant %h cyc %b want 0000 0", grantO, sCycO); end
    tick();
    nChecks++; if (grantO !== 16'h0008) begin nFail++; $display("[TB] FAIL single_grant got %h want 0008", grantO); end
    nChecks++; if ({sCycO, sStbO, sWeO} !== 3'b111 || sSelO !== 4'hA) begin nFail++; $display("[TB] FAIL single_ctrl got %b sel %h want 111 a", {sCycO, sStbO, sWeO}, sSelO); end
    nChecks++; if (sAdrO !== 32'hA000_0030 || sDatO !== 32'h1234_5678) begin nFail++; $display("[TB] FAIL single_route adr %h dat %h want a0000030 12345678", sAdrO, sDatO); end
    mStbI[3] = 1'b0;
    #1;
    nChecks++; if ({sCycO, sStbO} !== 2'b10) begin nFail++; $display("[TB] FAIL single_stb_gap got %b want 10", {sCycO, sStbO}); end
    mStbI[3] = 1'b1; mCycI[9] = 1'b1; sAckI = 1'b1; sDatI = 32'hCAFE_F00D;
    #1;
    nChecks++; if (mAckO !== 16'h0008 || mErrO !== 16'h0000) begin nFail++; $display("[TB] FAIL single_ack ack %h err %h want 0008 0000", mAckO, mErrO); end
    nChecks++; if (mDatO[0] !== 32'hCAFE_F00D || mDatO[15] !== 32'hCAFE_F00D) begin nFail++; $display("[TB] FAIL single_broadcast got %h %h want cafef00d", mDatO[0], mDatO[15]); end
    sAckI = 1'b0; sRtyI = 1'b1;
    #1;
    nChecks++; if (mRtyO !== 16'h0008 || mAckO !== 16'h0000) begin nFail++; $display("[TB] FAIL single_rty rty %h ack %h want 0008 0000", mRtyO, mAckO); end
    sRtyI = 1'b0; sErrI = 1'b1;
    #1;
    nChecks++; if (mErrO !== 16'h0008) begin nFail++; $display("[TB] FAIL single_err got %h want 0008", mErrO); end
    sErrI = 1'b0; mCycI[3] = 1'b0; mStbI[3] = 1'b0;
    tick();
    nChecks++; if (grantO !== 16'h0000) begin nFail++; $display("[TB] FAIL single_release got %h want 0000", grantO); end
    clearInputs();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] expOrder [4];
    int owner;
    expOrder[0] = 16'h0001; expOrder[1] = 16'h0020;
    expOrder[2] = 16'h8000; expOrder[3] = 16'h0001;
    doReset();
    mCycI[0] = 1'b1; mCycI[5] = 1'b1; mCycI[15] = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      nChecks++; if (grantO !== expOrder[k]) begin nFail++; $display("[TB] FAIL rr_grant_%0d got %h want %h", k, grantO, expOrder[k]); end
      if (k == 3) break;
      owner = (k == 0) ? 0 : (k == 1) ? 5 : 15;
      mCycI[owner] = 1'b0;
      tick();
      nChecks++; if (grantO !== 16'h0000) begin nFail++; $display("[TB] FAIL rr_idle_%0d got %h want 0000", k, grantO); end
      mCycI[owner] = 1'b1;
      tick();
    end
    clearInputs();
    tick();
  endtask

  task automatic test_back_to_back();
    doReset();
    mCycI[2] = 1'b1; mStbI[2] = 1'b1; mCtiI[2] = 3'b010; mAdrI[2] = 32'h0000_0100;
    tick();
    mCycI[1] = 1'b1; mStbI[1] = 1'b1;
    for (int b = 0; b < 4; b++) begin
      mCtiI[2] = (b == 3) ? 3'b111 : 3'b010;
      mAdrI[2] = 32'h0000_0100 + 32'(4 * b);
      sAckI = 1'b1;
      #1;
      nChecks++; if (grantO !== 16'h0004 || mAckO !== 16'h0004) begin nFail++; $display("[TB] FAIL burst_beat_%0d grant %h ack %h want 0004 0004", b, grantO, mAckO); end
      nChecks++; if (sCtiO !== mCtiI[2] || sAdrO !== mAdrI[2]) begin nFail++; $display("[TB] FAIL burst_route_%0d cti %b adr %h want %b %h", b, sCtiO, sAdrO, mCtiI[2], mAdrI[2]); end
      tick();
    end
    sAckI = 1'b0; mCycI[2] = 1'b0; mStbI[2] = 1'b0;
    #1;
    nChecks++; if (grantO !== 16'h0004) begin nFail++; $display("[TB] FAIL burst_hold got %h want 0004", grantO); end
    tick();
    nChecks++; if (grantO !== 16'h0000) begin nFail++; $display("[TB] FAIL burst_idle got %h want 0000", grantO); end
    tick();
    nChecks++; if (grantO !== 16'h0002) begin nFail++; $display("[TB] FAIL burst_next got %h want 0002", grantO); end
    clearInputs();
    tick();
  endtask

  task automatic test_reset_mid_burst();
    doReset();
    mCycI[4] = 1'b1; mStbI[4] = 1'b1; mCtiI[4] = 3'b010;
    tick();
    sAckI = 1'b1;
    tick();
    #2;
    rst = 1'b0;
    #1;
    nChecks++; if ({sCycO, sStbO} !== 2'b00 || grantO !== 16'h0000) begin nFail++; $display("[TB] FAIL midrst_abort cyc/stb %b grant %h want 00 0000", {sCycO, sStbO}, grantO); end
    nChecks++; if (mAckO !== 16'h0000) begin nFail++; $display("[TB] FAIL midrst_ack got %h want 0000", mAckO); end
    clearInputs();
    mCycI[7] = 1'b1; mStbI[7] = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    nChecks++; if (grantO !== 16'h0080) begin nFail++; $display("[TB] FAIL midrst_regrant got %h want 0080", grantO); end
    clearInputs();
    tick();
  endtask

  task automatic test_timeout();
    logic [N-1:0] expErr;
    logic         expTo;
    doReset();
    mCycI[6] = 1'b1; mStbI[6] = 1'b1;
    tick();
    for (int k = 1; k <= 16; k++) begin
      sAckI = (k == 16);
      #1;
      expErr = 16'h0000;
      expTo  = 1'b0;
`ifdef MPSOC_WB_ARB_TIMEOUT_EN
      if (k == TO) begin expErr = 16'h0040; expTo = 1'b1; end
`endif
      nChecks++; if (mErrO !== expErr || timeoutO !== expTo) begin nFail++; $display("[TB] FAIL wdog_cycle_%0d err %h to %b want %h %b", k, mErrO, timeoutO, expErr, expTo); end
      nChecks++; if (sStbO !== ~expTo) begin nFail++; $display("[TB] FAIL wdog_stb_%0d got %b want %b", k, sStbO, ~expTo); end
      if (k == 16) begin
        nChecks++; if (mAckO !== 16'h0040) begin nFail++; $display("[TB] FAIL wdog_ack_precedence got %h want 0040", mAckO); end
      end
      tick();
    end
    clearInputs();
    tick();
  endtask

  initial begin
    rst = 1'b0;
    clearInputs();
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_reset_mid_burst();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/mpsoc_wb_ext_arbiter.md
MPSOC_WB_EXT_ARBITER -- requirements
Module: mpsoc_wb_ext_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, Wishbone address width.
REQ-002 SHALL have parameter DW, default 32, Wishbone data width.
REQ-003 SHALL have parameter NODES, default 16, number of requesting masters (must be 2 or more).
REQ-004 SHALL have parameter TIMEOUT, default 255, slave-response watchdog limit in cycles (1..65535).
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports m_adr_i/m_dat_i/m_sel_i/m_we_i/m_bte_i/m_cti_i/m_cyc_i/m_stb_i  input  [NODES][AW]/[NODES][DW]/[NODES][4]/[NODES]/[NODES][2]/[NODES][3]/[NODES]/[NODES]  master request buses.
REQ-008 SHALL have ports m_ack_o/m_err_o/m_rty_o  output  [NODES] each  per-master responses.
REQ-009 SHALL have port m_dat_o  output  [NODES][DW]  per-master read data.
REQ-010 SHALL have ports s_adr_o/s_dat_o/s_sel_o/s_we_o/s_bte_o/s_cti_o/s_cyc_o/s_stb_o  output  AW/DW/4/1/2/3/1/1  shared slave (SPRAM) request.
REQ-011 SHALL have ports s_ack_i/s_err_i/s_rty_i  input  1 each; s_dat_i  input  DW  slave response.
REQ-012 SHALL have port grant_o  output  [NODES]  one-hot current owner (all zero when idle).
REQ-013 SHALL have port timeout_o  output  1  one-cycle pulse on watchdog expiry.

Function
REQ-014 SHALL implement FSM states IDLE and BUSY plus a round-robin pointer ptr (log2 NODES bits).
REQ-015 In IDLE with any m_cyc_i high, SHALL register grant to the first requester at index ptr, ptr+1, ... (mod NODES) and enter BUSY next cycle; arbitration latency is exactly 1 cycle, with no same-cycle grant.
REQ-016 In BUSY, SHALL route the granted master's adr/dat/sel/we/bte/cti combinationally to s_*; s_cyc_o = m_cyc_i[g], s_stb_o = m_stb_i[g].
REQ-017 In IDLE, SHALL drive s_cyc_o = s_stb_o = 0; other s_* outputs are don't-care but SHALL be driven to 0.
REQ-018 SHALL route s_ack_i/s_err_i/s_rty_i only to the granted master; all other m_ack_o/m_err_o/m_rty_o SHALL be 0.
REQ-019 SHALL broadcast s_dat_i to every m_dat_o.
REQ-020 SHALL hold the grant for the whole cycle of the owner, including bursts (cti 3'b010) and stb gaps, until m_cyc_i[g] = 0.
REQ-021 When m_cyc_i[g] falls in BUSY, SHALL go to IDLE and set ptr = g+1 mod NODES (wrap NODES-1 -> 0); a new grant follows no earlier than 1 cycle later.
REQ-022 Requests from non-granted masters SHALL be ignored (no ack/err) until they are granted; a requester SHALL never wait more than NODES-1 foreign tenures.
REQ-023 A single requester SHALL be re-granted after each release with one IDLE cycle between tenures.
REQ-024 Requests arriving in the same cycle as a release SHALL be evaluated in the following IDLE cycle using the updated ptr.

Reset
REQ-025 While rst = 0, SHALL asynchronously force state IDLE, ptr = 0, grant_o = 0, watchdog = 0, timeout_o = 0, all m_ack_o/m_err_o/m_rty_o = 0, and s_cyc_o = s_stb_o = 0.
REQ-026 Reset asserted mid-burst SHALL abort the transfer without any response to the master; after deassertion, arbitration restarts from ptr = 0.

Configuration
REQ-027 Macro MPSOC_WB_ARB_TIMEOUT_EN SHALL compile in the watchdog.
REQ-028 With the macro defined: a counter SHALL increment each BUSY cycle with s_stb_o = 1 and no s_ack_i/s_err_i/s_rty_i, and clear otherwise. On reaching TIMEOUT it SHALL, in that cycle, assert m_err_o[g] for 1 cycle, pulse timeout_o, force s_stb_o = 0 and clear the counter. A slave response in the same cycle SHALL take precedence, with no error.
REQ-029 Without the macro: there SHALL be no counter, timeout_o SHALL be tied to 0, and no error SHALL be generated internally.

Verification
REQ-030 Reset then m_cyc_i[3] = 1 at cycle 0 -> grant_o = 16'h0008 at cycle 1; s_stb_o follows m_stb_i[3]; ack returned only on m_ack_o[3].
REQ-031 Masters 0, 5 and 15 requesting continuously, with ptr = 0 after reset -> grant order 0, 5, 15, 0 with a 1 IDLE cycle between each tenure.
REQ-032 Master 2 runs a 4-beat burst (cti 010, 010, 010, 111) while master 1 requests -> grant stays 2 for all 4 acks; master 1 is granted 2 cycles after m_cyc_i[2] falls.
REQ-033 rst pulled low during beat 2 of a burst -> s_cyc_o = 0 immediately, no m_ack_o pulse; after release with master 7 requesting, grant_o = 16'h0080.
REQ-034 With MPSOC_WB_ARB_TIMEOUT_EN and TIMEOUT = 8, slave never acks -> m_err_o[g] = 1 and timeout_o = 1 on the 8th stalled cycle, then 0; without the macro -> stall persists and timeout_o stays 0.
